bcd_seq_multiplier: RTL and testbench

- Sequential, parametrised multi-digit BCD multiplier: multiplies two DIGITS-digit packed BCD operands into a 2*DIGITS-digit packed BCD product.
- Shift-and-add with decimal correction; no binary conversion.
- Adds a start/busy/done handshake and per-operand validity flags.
- Arithmetic unit for the display/calculator datapath; replaces the single-digit combinational multiplier.

---
 rtl/bcd_seq_multiplier.sv | 207 ++++++++++++++++++++
 tb/tb_bcd_seq_multiplier.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_multiplier.sv
// ---------------------------------------------------------------------------
// bcd_seq_multiplier
//
// Sequential multi-digit packed-BCD multiplier. It works by shift-and-add with
// decimal correction and never converts to binary. Starting from the most
// significant digit of the multiplier, each step shifts the accumulator one
// BCD digit left. It then adds the multiplicand once for every unit of the
// current multiplier digit.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high reset
//   start    : operation request, sampled only while idle
//   bcd_a    : multiplicand, DIGITS packed BCD digits, MSD in MSBs
//   bcd_b    : multiplier, same format
//   busy     : high while an operation is in progress
//   done     : one-cycle pulse, results valid from this cycle on
//   bcd_res  : 2*DIGITS-digit packed BCD product, or error pattern
//   err_a    : last bcd_a contained a nibble > 9
//   err_b    : last bcd_b contained a nibble > 9
// ---------------------------------------------------------------------------
module bcd_seq_multiplier #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_a,
   input  logic [4*DIGITS-1:0]   bcd_b,
   output logic                  busy,
   output logic                  done,
   output logic [8*DIGITS-1:0]   bcd_res,
   output logic                  err_a,
   output logic                  err_b
);

   localparam int OP_W  = 4 * DIGITS;
   localparam int ACC_W = 8 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SHIFT,
      S_ADD,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [OP_W-1:0]    ra_q, ra_d;
   logic [OP_W-1:0]    rb_q, rb_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               va_q, va_d;
   logic               vb_q, vb_d;
   logic [ACC_W-1:0]   res_q, res_d;
   logic               erra_q, erra_d;
   logic               errb_q, errb_d;
   logic               done_q, done_d;

   // True when any nibble of an operand is not a decimal digit.
   function automatic logic has_bad_digit(input logic [OP_W-1:0] x);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (x[i*4 +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Digit-wise ripple-carry BCD addition. A digit sum above 9 gets 6 added
   // so that the low nibble wraps to the correct decimal digit. A carry out
   // of the top digit cannot occur because the product always fits.
   function automatic logic [ACC_W-1:0] bcd_add(input logic [ACC_W-1:0] x,
                                                input logic [ACC_W-1:0] y);
      logic [ACC_W-1:0] s;
      logic [4:0]       dsum;
      logic             c;
      s = '0;
      c = 1'b0;
      for (int i = 0; i < 2 * DIGITS; i++) begin
         dsum = {1'b0, x[i*4 +: 4]} + {1'b0, y[i*4 +: 4]} + {4'b0000, c};
         if (dsum > 5'd9) begin
            dsum = dsum + 5'd6;
            c    = 1'b1;
         end else begin
            c    = 1'b0;
         end
         s[i*4 +: 4] = dsum[3:0];
      end
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         va_q    <= 1'b0;
         vb_q    <= 1'b0;
         res_q   <= '0;
         erra_q  <= 1'b0;
         errb_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         va_q    <= va_d;
         vb_q    <= vb_d;
         res_q   <= res_d;
         erra_q  <= erra_d;
         errb_q  <= errb_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      va_d    = va_q;
      vb_d    = vb_q;
      res_d   = res_q;
      erra_d  = erra_q;
      errb_d  = errb_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ra_d    = bcd_a;
               rb_d    = bcd_b;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            va_d = has_bad_digit(ra_q);
            vb_d = has_bad_digit(rb_q);
            if (va_d || vb_d) begin
               // Error pattern: all-ones half marks each offending operand.
               acc_d   = {{OP_W{va_d}}, {OP_W{vb_d}}};
               state_d = S_DONE;
            end else begin
               acc_d   = '0;
               idx_d   = IDX_TOP;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            acc_d = acc_q << 4;
            cnt_d = rb_q[{idx_q, 2'b00} +: 4];
            if (cnt_d == 4'd0) begin
               if (idx_q == '0) state_d = S_DONE;
               else             idx_d   = idx_q - IDX_W'(1);
            end else begin
               state_d = S_ADD;
            end
         end

         S_ADD: begin
            acc_d = bcd_add(acc_q, {{OP_W{1'b0}}, ra_q});
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               if (idx_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q - IDX_W'(1);
                  state_d = S_SHIFT;
               end
            end
         end

         S_DONE: begin
            // Results are registered here. The done pulse therefore lines up
            // with the cycle in which the new bcd_res becomes visible.
            res_d   = acc_q;
            erra_d  = va_q;
            errb_d  = vb_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign bcd_res = res_q;
   assign err_a   = erra_q;
   assign err_b   = errb_q;

endmodule

// File: tb/tb_bcd_seq_multiplier.sv
module tb_bcd_seq_multiplier;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // One instance per digit count in the test plan.
   logic        st1, st2, st4;
   logic [3:0]  a1, b1;
   logic [7:0]  a2, b2;
   logic [15:0] a4, b4;
   logic        busy1, busy2, busy4, done1, done2, done4;
   logic [7:0]  res1;
   logic [15:0] res2;
   logic [31:0] res4;
   logic        ea1, eb1, ea2, eb2, ea4, eb4;

   bcd_seq_multiplier #(.DIGITS(1)) dut1 (
      .clk(clk), .reset(reset), .start(st1), .bcd_a(a1), .bcd_b(b1),
      .busy(busy1), .done(done1), .bcd_res(res1), .err_a(ea1), .err_b(eb1));
   bcd_seq_multiplier #(.DIGITS(2)) dut2 (
      .clk(clk), .reset(reset), .start(st2), .bcd_a(a2), .bcd_b(b2),
      .busy(busy2), .done(done2), .bcd_res(res2), .err_a(ea2), .err_b(eb2));
   bcd_seq_multiplier #(.DIGITS(4)) dut4 (
      .clk(clk), .reset(reset), .start(st4), .bcd_a(a4), .bcd_b(b4),
      .busy(busy4), .done(done4), .bcd_res(res4), .err_a(ea4), .err_b(eb4));

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] last_res;
   int          last_lat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- observation muxes ----------------
   function automatic logic obs_busy(input int d);
      return (d == 1) ? busy1 : (d == 2) ? busy2 : busy4;
   endfunction
   function automatic logic obs_done(input int d);
      return (d == 1) ? done1 : (d == 2) ? done2 : done4;
   endfunction
   function automatic logic [31:0] obs_res(input int d);
      return (d == 1) ? {24'h0, res1} : (d == 2) ? {16'h0, res2} : res4;
   endfunction
   function automatic logic obs_ea(input int d);
      return (d == 1) ? ea1 : (d == 2) ? ea2 : ea4;
   endfunction
   function automatic logic obs_eb(input int d);
      return (d == 1) ? eb1 : (d == 2) ? eb2 : eb4;
   endfunction

   // ---------------- reference model (decimal arithmetic) ----------------
   function automatic bit bcd_bad(input logic [15:0] x, input int d);
      bit bad = 0;
      for (int i = 0; i < d; i++) if (x[i*4 +: 4] > 4'd9) bad = 1;
      return bad;
   endfunction
   function automatic longint bcd_val(input logic [15:0] x, input int d);
      longint v = 0;
      for (int i = d - 1; i >= 0; i--) v = v * 10 + longint'(x[i*4 +: 4]);
      return v;
   endfunction
   function automatic int digit_sum(input logic [15:0] x, input int d);
      int s = 0;
      for (int i = 0; i < d; i++) s += int'(x[i*4 +: 4]);
      return s;
   endfunction
   function automatic logic [31:0] to_bcd(input longint v, input int d);
      logic [31:0] r = '0;
      longint t = v;
      for (int i = 0; i < 2 * d; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction
   function automatic logic [31:0] model_res(input int d, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] m = (32'h1 << (4 * d)) - 32'h1;
      bit ba = bcd_bad(a, d);
      bit bb = bcd_bad(b, d);
      if (ba || bb) return (ba ? (m << (4 * d)) : 32'h0) | (bb ? m : 32'h0);
      return to_bcd(bcd_val(a, d) * bcd_val(b, d), d);
   endfunction
   function automatic int model_lat(input int d, input logic [15:0] a, input logic [15:0] b);
      if (bcd_bad(a, d) || bcd_bad(b, d)) return 2;
      return d + digit_sum(b, d) + 2;
   endfunction

   function automatic logic [15:0] rand_bcd(input int d, input bit allow_bad);
      logic [15:0] x = '0;
      for (int i = 0; i < d; i++) begin
         if (allow_bad && ($urandom_range(0, 9) == 0)) x[i*4 +: 4] = 4'($urandom_range(10, 15));
         else                                          x[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      return x;
   endfunction

   task automatic set_start(input int d, input logic v, input logic [15:0] a, input logic [15:0] b);
      case (d)
         1: begin a1 = a[3:0]; b1 = b[3:0]; st1 = v; end
         2: begin a2 = a[7:0]; b2 = b[7:0]; st2 = v; end
         default: begin a4 = a; b4 = b; st4 = v; end
      endcase
   endtask

   // Runs one full operation (called #1 after a rising edge) and checks it.
   task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] er = model_res(d, a, b);
      int el = model_lat(d, a, b);
      int k = 0;
      int busyc;
      set_start(d, 1'b1, a, b);
      @(posedge clk); #1;
      set_start(d, 1'b0, ~a, ~b);   // later input changes must not matter
      chk($sformatf("busy_after_start d%0d", d), {31'h0, obs_busy(d)}, 32'h1);
      busyc = 1;
      while (obs_done(d) !== 1'b1 && k < 300) begin
         @(posedge clk); #1;
         k++;
         if (obs_done(d) !== 1'b1 && obs_busy(d) === 1'b1) busyc++;
      end
      last_res = obs_res(d);
      last_lat = k;
      chk($sformatf("done_seen d%0d a=%h b=%h", d, a, b), {31'h0, obs_done(d)}, 32'h1);
      chk($sformatf("latency d%0d a=%h b=%h", d, a, b), k, el);
      chk($sformatf("busy_cycles d%0d a=%h b=%h", d, a, b), busyc, el);
      chk($sformatf("busy_low_at_done d%0d", d), {31'h0, obs_busy(d)}, 32'h0);
      chk($sformatf("res d%0d a=%h b=%h", d, a, b), obs_res(d), er);
      chk($sformatf("err_a d%0d a=%h", d, a), {31'h0, obs_ea(d)}, {31'h0, bcd_bad(a, d)});
      chk($sformatf("err_b d%0d b=%h", d, b), {31'h0, obs_eb(d)}, {31'h0, bcd_bad(b, d)});
      @(posedge clk); #1;
      chk($sformatf("done_pulse_one_cycle d%0d", d), {31'h0, obs_done(d)}, 32'h0);
      chk($sformatf("res_hold d%0d", d), obs_res(d), er);
   endtask

   initial begin
      int k;
      bit seen;
      reset = 1'b1;
      set_start(1, 1'b0, 16'h0, 16'h0);
      set_start(2, 1'b0, 16'h0, 16'h0);
      set_start(4, 1'b0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {29'h0, busy1, busy2, busy4}, 32'h0);
      chk("reset_done", {29'h0, done1, done2, done4}, 32'h0);
      chk("reset_res2", {16'h0, res2}, 32'h0);
      chk("reset_res4", res4, 32'h0);
      chk("reset_err", {26'h0, ea1, eb1, ea2, eb2, ea4, eb4}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed test-plan cases, also checked against literal constants.
      run_op(2, 16'h12, 16'h34);
      chk("plan_12x34_res", last_res, 32'h0408);
      chk("plan_12x34_lat", last_lat, 11);
      run_op(2, 16'h99, 16'h99);
      chk("plan_99x99_res", last_res, 32'h9801);
      chk("plan_99x99_lat", last_lat, 22);
      run_op(2, 16'h57, 16'h00);
      chk("plan_57x00_lat", last_lat, 4);
      run_op(2, 16'h00, 16'h10);
      chk("plan_00x10_lat", last_lat, 5);
      run_op(2, 16'h1A, 16'h05);
      chk("plan_errA_res", last_res, 32'hFF00);
      run_op(2, 16'h23, 16'hF0);
      chk("plan_errB_res", last_res, 32'h00FF);
      run_op(2, 16'hCB, 16'h9E);
      chk("plan_errAB_res", last_res, 32'hFFFF);
      run_op(1, 16'h9, 16'h9);
      chk("plan_d1_res", last_res, 32'h81);
      chk("plan_d1_lat", last_lat, 12);
      run_op(4, 16'h1234, 16'h5678);
      chk("plan_d4_res", last_res, 32'h07006652);
      chk("plan_d4_lat", last_lat, 32);

      // start while busy (mid-run and in the DONE cycle) is ignored.
      set_start(2, 1'b1, 16'h99, 16'h99);
      @(posedge clk); #1;                       // E0
      set_start(2, 1'b0, 16'h0, 16'h0);
      repeat (4) @(posedge clk);
      #1;                                       // after E4
      set_start(2, 1'b1, 16'h11, 16'h11);
      @(posedge clk); #1;                       // E5 sees start while busy
      set_start(2, 1'b0, 16'h0, 16'h0);
      repeat (15) @(posedge clk);
      #1;                                       // after E20
      chk("hs_no_early_done", {31'h0, done2}, 32'h0);
      @(posedge clk); #1;                       // after E21: DONE state
      chk("hs_busy_in_done", {31'h0, busy2}, 32'h1);
      set_start(2, 1'b1, 16'h22, 16'h22);
      @(posedge clk); #1;                       // E22 raises done
      set_start(2, 1'b0, 16'h0, 16'h0);
      chk("hs_done", {31'h0, done2}, 32'h1);
      chk("hs_res", {16'h0, res2}, 32'h9801);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done2 === 1'b1 || busy2 === 1'b1) seen = 1;
      end
      chk("hs_no_queued_op", {31'h0, seen}, 32'h0);
      run_op(2, 16'h45, 16'h67);

      // Reset five cycles into a run aborts it.
      set_start(2, 1'b1, 16'h99, 16'h98);
      @(posedge clk); #1;
      set_start(2, 1'b0, 16'h0, 16'h0);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", {31'h0, busy2}, 32'h0);
      chk("abort_done", {31'h0, done2}, 32'h0);
      chk("abort_res", {16'h0, res2}, 32'h0);
      chk("abort_err", {30'h0, ea2, eb2}, 32'h0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done2 === 1'b1 || busy2 === 1'b1) seen = 1;
      end
      chk("abort_no_done", {31'h0, seen}, 32'h0);

      // Randomized operations against the decimal reference model.
      for (int i = 0; i < 25; i++) run_op(2, rand_bcd(2, 1'b1), rand_bcd(2, 1'b1));
      for (int i = 0; i < 10; i++) run_op(1, rand_bcd(1, 1'b1), rand_bcd(1, 1'b1));
      for (int i = 0; i < 10; i++) run_op(4, rand_bcd(4, 1'b1), rand_bcd(4, 1'b1));
      run_op(4, 16'h9999, 16'h9999);
      run_op(1, 16'h0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
